// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one word load/store per request, fixed latency, held response.
// Optional macro DMEM_ERR_EN: flag out-of-range addresses with resp_err and suppress the store.
module dmem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2,
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [1:0]        dbg_state
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int CW = $clog2(LATENCY) + 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     idx_q;
  logic              write_q;
  logic [DATA_W-1:0] wdata_q;
  logic              err_q;
  logic              resp_valid_q;
  logic              resp_write_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  logic addr_err;
  logic access;
  logic store_en;
  logic unused_addr_bits;

  // Handshakes: a request transfers on a posedge where req_valid && req_ready;
  // a response transfers on a posedge where resp_valid && resp_ready. Each side
  // holds its payload stable while valid is high and not yet taken.
  assign req_ready = (state == IDLE);
  assign access    = (state == WAIT) && (cnt == '0);
  assign store_en  = access && write_q && !err_q;

`ifdef DMEM_ERR_EN
  assign addr_err = |req_addr[ADDR_W-1:IW+2];
`else
  assign addr_err = 1'b0;
`endif

  // Byte-offset bits never select anything; upper bits only matter with error checking.
  assign unused_addr_bits = ^{req_addr[1:0], req_addr[ADDR_W-1:IW+2]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      idx_q        <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      err_q        <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            state   <= WAIT;
            cnt     <= CW'(LATENCY - 1);
            idx_q   <= req_addr[IW+1:2];
            write_q <= req_write;
            wdata_q <= req_wdata;
            err_q   <= addr_err;
          end
        end
        WAIT: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            // Access edge: the response payload is captured here and frozen through RESP.
            state        <= RESP;
            resp_valid_q <= 1'b1;
            resp_write_q <= write_q;
            resp_err_q   <= err_q;
            resp_rdata_q <= (write_q || err_q) ? '0 : mem[idx_q];
          end
        end
        RESP: begin
          if (resp_ready) begin
            state        <= IDLE;
            resp_valid_q <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (store_en) begin
      mem[idx_q] <= wdata_q;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_write = resp_write_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign dbg_state  = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed scenarios plus randomized traffic
// against an array-based memory model; honours DMEM_ERR_EN when defined.
module tb_dmem_responder;

  localparam int DEPTH = 256;
  localparam int LAT   = 2;
  localparam int DW    = 32;
  localparam int AW    = 32;
`ifdef DMEM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_write;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;
  logic [1:0]    dbg_state;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_acc = 0;
  int acc_log[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] ref_mem [DEPTH];

  dmem_responder #(
    .DEPTH_WORDS(DEPTH), .LATENCY(LAT), .DATA_W(DW), .ADDR_W(AW)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / monitors ----------------
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Inputs are stable at the negedge, so a visible handshake here transfers on the next posedge.
  always @(negedge clock) begin
    if (req_valid && req_ready) begin
      n_acc <= n_acc + 1;
      acc_log.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model ----------------
  function automatic int ref_idx(input logic [AW-1:0] a);
    return int'((a >> 2) % DEPTH);
  endfunction

  function automatic bit ref_err(input logic [AW-1:0] a);
    return ERR_EN && ((a >> (2 + $clog2(DEPTH))) != 0);
  endfunction

  task automatic clear_ref();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    exp_q.delete();
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic apply_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_write", resp_write, 0);
    check("rst_resp_err", resp_err, 0);
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    clear_ref();
    @(posedge clock);
    #1;
    check("rst_req_ready", req_ready, 1);
  endtask

  // One full transaction; hold>0 withholds resp_ready that many cycles while a
  // spurious request is presented, which must not be taken.
  task automatic do_txn(input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d, input int hold);
    logic [DW-1:0] exp_d;
    bit exp_e;
    int n;
    int acc0;
    exp_e = ref_err(a);
    exp_d = (w || exp_e) ? '0 : ref_mem[ref_idx(a)];
    if (w && !exp_e) ref_mem[ref_idx(a)] = d;
    exp_q.push_back(exp_d);
    acc0 = n_acc;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_valid  = 1'b1;
    resp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clock); #1; n++;
    end
    if (!req_ready) begin
      check("accept_timeout", 0, 1);
      req_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clock); #1;
    // Scramble request inputs: the DUT must have latched them at accept.
    req_valid = 1'b0;
    req_write = 1'($urandom);
    req_addr  = $urandom;
    req_wdata = $urandom;
    check("req_ready_busy", req_ready, 0);
    n = 0;
    while (!resp_valid && n < 50) begin
      @(posedge clock); #1; n++;
    end
    check("latency", n, LAT);
    exp_d = exp_q.pop_front();
    check("resp_rdata", resp_rdata, exp_d);
    check("resp_write", resp_write, w);
    check("resp_err", resp_err, exp_e);
    if (hold > 0) begin
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = $urandom;
    end
    for (int k = 0; k < hold; k++) begin
      @(posedge clock); #1;
      check("hold_valid", resp_valid, 1);
      check("hold_rdata", resp_rdata, exp_d);
      check("hold_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    check("release_valid", resp_valid, 0);
    check("release_ready", req_ready, 1);
    check("accept_count", n_acc - acc0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [AW-1:0] a;
    apply_reset();

    // Reset state and a load from fresh storage.
    do_txn(1'b0, 32'h40, '0, 0);

    // Store then loads, including ignored byte-offset bits.
    do_txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
    do_txn(1'b0, 32'h10, '0, 0);
    do_txn(1'b0, 32'h13, '0, 0);

    // Backpressure with a spurious request, then the next request goes through.
    do_txn(1'b0, 32'h10, '0, 5);
    do_txn(1'b0, 32'h13, '0, 0);

    // Async reset while a nonzero load response is being held.
    do_txn(1'b1, 32'h8, 32'hA5A5, 0);
    req_write = 1'b0; req_addr = 32'h8; req_valid = 1'b1; resp_ready = 1'b0;
    @(posedge clock); #1;
    req_valid = 1'b0;
    repeat (LAT) @(posedge clock);
    #1;
    check("pre_rst_rdata", resp_rdata, 32'hA5A5);
    apply_reset();
    do_txn(1'b0, 32'h8, '0, 0);

    // Reset while a store is still waiting for its access edge.
    req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h1234; req_valid = 1'b1;
    @(posedge clock); #1;
    req_valid = 1'b0;
    apply_reset();
    do_txn(1'b0, 32'h20, '0, 0);

    // Back-to-back period with resp_ready high.
    acc_log.delete();
    for (int i = 0; i < 4; i++) do_txn(1'b0, 32'($urandom_range(0, 15)) << 2, '0, 0);
    for (int i = 1; i < 4; i++) check("issue_period", acc_log[i] - acc_log[i-1], LAT + 2);

    // Out-of-range store: error with DMEM_ERR_EN, index wrap otherwise.
    do_txn(1'b1, 32'h400, 32'h55, 0);
    do_txn(1'b0, 32'h000, '0, 0);
    check("wrap_word0", ref_mem[0], ERR_EN ? 32'h0 : 32'h55);

    // Randomized traffic on a small index set to force reuse.
    for (int i = 0; i < 40; i++) begin
      a = {22'b0, 6'($urandom_range(0, 15)), 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = a | (32'h1 << $urandom_range(10, 31));
      do_txn(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
